sequential_divider: RTL

Sequential restoring shift-subtract unsigned divider. It is the inverse companion of the shift-add multiplier and reuses the same style of building blocks: shift registers, a counter, an adder/subtractor and muxes. Controller and datapath are contained in one block with a start/done handshake. It accepts a dividend and divisor on `start` and produces quotient and remainder after WIDTH iteration cycles.

---
 rtl/sequential_divider.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sequential_divider.sv
// Restoring shift-subtract unsigned divider with start/done handshake, WIDTH iterations per operation.
// Define SEQUENTIAL_DIVIDER_DBZ_DETECT_EN to finish divide-by-zero in a single cycle with divByZero flagged.
module sequential_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero,
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: a request is taken when start=1 is sampled in IDLE; busy covers CALC and DONE,
    // done marks the single DONE cycle, and start outside IDLE is dropped.
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic             w_dbz;
    logic [WIDTH:0]   w_a_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH:0]   w_a_nxt;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_CALC) && (r_cnt == LAST);

`ifdef SEQUENTIAL_DIVIDER_DBZ_DETECT_EN
    assign w_dbz = (divisor == '0);
`else
    assign w_dbz = 1'b0;
`endif

    // One restoring step: shift {A,Q} left, keep the subtraction only if it did not borrow.
    assign w_a_sh  = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_trial = w_a_sh - {1'b0, r_d};
    assign w_fits  = ~w_trial[WIDTH];
    assign w_a_nxt = w_fits ? w_trial : w_a_sh;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = w_dbz ? S_DONE : S_CALC;
            S_CALC: if (w_last) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_q   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_d   <= divisor;
            r_cnt <= '0;
            if (w_dbz) begin
                r_q <= '1;
                r_a <= {1'b0, dividend};
            end else begin
                r_q <= dividend;
                r_a <= '0;
            end
        end else if (r_state == S_CALC) begin
            r_a   <= w_a_nxt;
            r_q   <= {r_q[WIDTH-2:0], w_fits};
            r_cnt <= r_cnt + CW'(1);
        end
    end

`ifdef SEQUENTIAL_DIVIDER_DBZ_DETECT_EN
    logic r_dbz;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dbz <= w_dbz;
        end
    end
    assign divByZero = r_dbz;
`else
    assign divByZero = 1'b0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_q;
    assign remainder = r_a[WIDTH-1:0];
    assign state_dbg = r_state;

endmodule
